// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 decryptor datapath.
//   - state_e      : control FSM states of the InvShiftRows/InvSubBytes stage
//   - AES_BLOCK_W  : state width in bits
//   - AES_BYTES    : state width in bytes
//   - inv_shift_src: InvShiftRows as an index map (output byte -> source byte)
// Byte k of a state occupies bits [127-8k -: 8]; s[r][c] is byte 4c+r.
package aes_dec_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Output s[r][c] comes from input s[r][(c-r) mod 4].
    function automatic int inv_shift_src(input int k);
        int r;
        int c;
        r = k % 4;
        c = k / 4;
        return 4 * ((c + 4 - r) % 4) + r;
    endfunction

endpackage

// File: rtl/inv_sub_shift_stage_if.sv
// Valid/ready stream bundle for the InvShiftRows/InvSubBytes stage.
//   in_valid/in_ready/in_data    : block entering the stage
//   out_valid/out_ready/out_data : finished block leaving the stage
// master = the surrounding datapath, slave = the stage itself.
interface inv_sub_shift_stage_if;
    import aes_dec_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/inv_sub_shift_stage_sbox.sv
// AES inverse S-box, one byte, purely combinational.
//   in_byte  : byte to substitute
//   out_byte : InvSubBytes(in_byte)
// Computed as the inverse affine transform followed by inversion in
// GF(2^8) mod x^8+x^4+x^3+x+1 (0 maps to 0).
module inv_sub_shift_stage_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 for x != 0, and 0 for x == 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = gf_mul(x, x);
        res = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    logic [7:0] affine;

    // NOTE: every always_comb output gets a value on every path (here by a
    // full loop) so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            affine[i] = in_byte[(i + 2) % 8] ^ in_byte[(i + 5) % 8]
                      ^ in_byte[(i + 7) % 8] ^ INV_AFFINE_C[i];
        end
        out_byte = gf_inv(affine);
    end

endmodule

// File: rtl/inv_sub_shift_stage.sv
// AES-128 decryption round stage: InvShiftRows then InvSubBytes on one
// 128-bit state, SBOX_LANES bytes substituted per cycle.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of inv_sub_shift_stage_if (in_* / out_* streams)
//   blk_count  : completed output handshakes, only when the macro
//                INV_SUB_SHIFT_BLKCNT_EN is defined
// A block is accepted in IDLE (or DONE when the previous one leaves in the
// same cycle), shifted by wiring into the state register, then substituted
// over PASSES = 16/SBOX_LANES BUSY cycles. out_data is the state register.
module inv_sub_shift_stage
    import aes_dec_pkg::*;
#(
    parameter int SBOX_LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_shift_stage_if.slave bus
`ifdef INV_SUB_SHIFT_BLKCNT_EN
    ,
    output logic [31:0]          blk_count
`endif
);

    localparam int PASSES = AES_BYTES / SBOX_LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       pass_q, pass_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic [AES_BLOCK_W-1:0] shifted;
    logic [7:0]             lane_in  [SBOX_LANES];
    logic [7:0]             lane_out [SBOX_LANES];
    logic                   accept;

    // InvShiftRows is pure wiring.
    always_comb begin
        shifted = '0;
        for (int k = 0; k < AES_BYTES; k++) begin
            shifted[AES_BLOCK_W-1-8*k -: 8] =
                bus.in_data[AES_BLOCK_W-1-8*inv_shift_src(k) -: 8];
        end
    end

    // Byte-lane mux: pass p feeds bytes p*SBOX_LANES .. p*SBOX_LANES+SBOX_LANES-1.
    always_comb begin
        for (int l = 0; l < SBOX_LANES; l++) begin
            lane_in[l] = data_q[AES_BLOCK_W-1-8*(int'(pass_q)*SBOX_LANES + l) -: 8];
        end
    end

    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        inv_sub_shift_stage_sbox u_sbox (
            .in_byte  (lane_in[l]),
            .out_byte (lane_out[l])
        );
    end

    assign accept = bus.in_valid & bus.in_ready;

    // State register.
    // NOTE: the data register is reset as well, because out_data is the
    // register itself and must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values of its inputs.
            state_q <= state_d;
            pass_q  <= pass_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    pass_d  = '0;
                    data_d  = shifted;
                end
            end
            BUSY: begin
                for (int l = 0; l < SBOX_LANES; l++) begin
                    data_d[AES_BLOCK_W-1-8*(int'(pass_q)*SBOX_LANES + l) -: 8] = lane_out[l];
                end
                pass_d = pass_q + CNT_W'(1);
                if (pass_q == LAST_PASS) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        state_d = BUSY;
                        pass_d  = '0;
                        data_d  = shifted;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. in_ready is gated by rst_n so it is low throughout reset and
    // rises as soon as reset is released; out_* come only from registers.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = (state_q == DONE);
        bus.out_data  = data_q;
        unique case (state_q)
            IDLE:    bus.in_ready = rst_n;
            DONE:    bus.in_ready = rst_n & bus.out_ready;
            default: bus.in_ready = 1'b0;
        endcase
    end

`ifdef INV_SUB_SHIFT_BLKCNT_EN
    logic [31:0] blk_count_q, blk_count_d;

    always_comb begin
        blk_count_d = blk_count_q;
        if (bus.out_valid && bus.out_ready) blk_count_d = blk_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blk_count_q <= '0;
        else        blk_count_q <= blk_count_d;
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_inv_sub_shift_stage.sv
// Bench for inv_sub_shift_stage: three instances (SBOX_LANES = 4, 1, 16)
// share clk/rst_n; instance 0 carries most scenarios. Expected values come
// from a table-driven model of InvSubBytes(InvShiftRows(x)) whose inverse
// S-box is built at time 0 by inverting the forward S-box, plus FIPS-197
// constants. Inputs change 1 time unit after the rising edge; outputs are
// sampled then or on the falling edge.
module tb_inv_sub_shift_stage;

    localparam int NDUT = 3;
    localparam logic [127:0] FIPS_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    function automatic int lanes_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 16;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NDUT-1:0] iv;
    logic [NDUT-1:0] ordy;
    logic [NDUT-1:0] ir;
    logic [NDUT-1:0] ov;
    logic [127:0]    id [NDUT];
    logic [127:0]    od [NDUT];
`ifdef INV_SUB_SHIFT_BLKCNT_EN
    logic [31:0]     bc [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_sub_shift_stage_if bus ();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = id[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign od[g]         = bus.out_data;

        inv_sub_shift_stage #(.SBOX_LANES(lanes_of(g))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
`ifdef INV_SUB_SHIFT_BLKCNT_EN
            ,
            .blk_count (bc[g])
`endif
        );
    end

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [7:0] inv_sb [256];

    // Carry-less multiply followed by polynomial long division.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Forward S-box by search for the multiplicative inverse, then inverted.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] f;
        logic [7:0] aff_c;
        aff_c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int z = 1; z < 256; z++) if (tb_gmul(8'(x), 8'(z)) == 8'h01) inv = 8'(z);
            for (int i = 0; i < 8; i++)
                f[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ aff_c[i];
            inv_sb[f] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] x);
        logic [7:0]   s [4][4];
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = x[127-8*(4*c+r) -: 8];
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(4*c+r) -: 8] = inv_sb[s[r][(c - r + 4) % 4]];
        return y;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present blk until accepted; returns one time unit after the accept edge.
    task automatic send(input int d, input logic [127:0] blk, output bit ok);
        int budget;
        budget = 100;
        ok     = 1'b0;
        iv[d]  = 1'b1;
        id[d]  = blk;
        while (budget > 0 && !ok) begin
            @(negedge clk);
            if (ir[d] === 1'b1) ok = 1'b1;
            tick();
            budget--;
        end
        iv[d] = 1'b0;
        id[d] = rnd128();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept dut%0d: in_ready never high within 100 cycles", d);
        end
    endtask

    // Edges from the accept edge (counted as 1) until out_valid is seen.
    task automatic wait_out(input int d, output int cycles);
        cycles = 1;
        while (ov[d] !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic xfer(input int d, input logic [127:0] blk,
                        output logic [127:0] obs, output int lat, output logic vld);
        bit ok;
        send(d, blk, ok);
        obs = 'x;
        lat = 0;
        vld = 1'b0;
        if (ok) begin
            wait_out(d, lat);
            vld = ov[d];
            obs = od[d];
            if (ordy[d]) tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        iv   = '0;
        ordy = '1;
        for (int d = 0; d < NDUT; d++) id[d] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks += 3;
            if (ir[d] !== 1'b0) begin failures++; $display("FAIL reset_in_ready dut%0d: got %b want 0", d, ir[d]); end
            if (ov[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, ov[d]); end
            if (od[d] !== '0)   begin failures++; $display("FAIL reset_out_data dut%0d: got %h want 0", d, od[d]); end
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin failures++; $display("FAIL release_in_ready dut%0d: got %b want 1", d, ir[d]); end
        end
        tick();
    endtask

    task automatic test_fips();
        logic [127:0] obs;
        int           lat;
        logic         vld;
        for (int d = 0; d < NDUT; d++) begin
            xfer(d, FIPS_IN, obs, lat, vld);
            checks += 3;
            if (vld !== 1'b1) begin failures++; $display("FAIL fips_valid dut%0d: got %b want 1", d, vld); end
            if (lat != 16 / lanes_of(d) + 1) begin
                failures++;
                $display("FAIL fips_latency dut%0d: got %0d want %0d", d, lat, 16 / lanes_of(d) + 1);
            end
            if (obs !== FIPS_OUT) begin failures++; $display("FAIL fips_data dut%0d: got %h want %h", d, obs, FIPS_OUT); end
        end
    endtask

    task automatic test_patterns();
        logic [127:0] obs;
        logic [127:0] exp;
        logic [127:0] blk;
        int           lat;
        logic         vld;
        xfer(0, {16{8'h63}}, obs, lat, vld);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL all63 : got %h want 0", obs); end

        blk = 128'h000102030405060708090a0b0c0d0e0f;
        exp = model(blk);
        xfer(0, blk, obs, lat, vld);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (obs[127-8*k -: 8] !== exp[127-8*k -: 8]) begin
                failures++;
                $display("FAIL ramp_byte%0d : got %h want %h", k, obs[127-8*k -: 8], exp[127-8*k -: 8]);
            end
        end

        for (int i = 0; i < 6; i++) begin
            blk = rnd128();
            xfer(i % NDUT, blk, obs, lat, vld);
            checks++;
            if (obs !== model(blk)) begin
                failures++;
                $display("FAIL random%0d dut%0d: got %h want %h", i, i % NDUT, obs, model(blk));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] blk;
        logic [127:0] blk2;
        int           lat;
        bit           ok;
        blk  = rnd128();
        blk2 = rnd128();
        ordy[0] = 1'b0;
        send(0, blk, ok);
        wait_out(0, lat);
        checks++;
        if (ov[0] !== 1'b1) begin failures++; $display("FAIL bp_valid : got %b want 1", ov[0]); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 3;
            if (ov[0] !== 1'b1) begin failures++; $display("FAIL bp_hold_valid%0d : got %b want 1", i, ov[0]); end
            if (od[0] !== model(blk)) begin failures++; $display("FAIL bp_hold_data%0d : got %h want %h", i, od[0], model(blk)); end
            if (ir[0] !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d : got %b want 0", i, ir[0]); end
            tick();
        end
        // Release: the output handshake and the next accept share one edge.
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        id[0]   = blk2;
        @(negedge clk);
        checks++;
        if (ir[0] !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready : got %b want 1", ir[0]); end
        tick();
        iv[0] = 1'b0;
        id[0] = rnd128();
        checks++;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL bp_after_hs_valid : got %b want 0", ov[0]); end
        wait_out(0, lat);
        checks += 2;
        if (lat != 5) begin failures++; $display("FAIL bp_next_latency : got %0d want 5", lat); end
        if (od[0] !== model(blk2)) begin failures++; $display("FAIL bp_next_data : got %h want %h", od[0], model(blk2)); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] blks [8];
        int  sent;
        int  got;
        int  cyc;
        int  last;
        bit  acc;
        bit  hs;
        for (int i = 0; i < 8; i++) blks[i] = rnd128();
        sent = 0; got = 0; cyc = 0; last = 0;
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        id[0]   = blks[0];
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            acc = (ir[0] === 1'b1) && iv[0];
            hs  = (ov[0] === 1'b1) && ordy[0];
            if (hs) begin
                checks++;
                if (od[0] !== model(blks[got])) begin
                    failures++;
                    $display("FAIL b2b_data%0d : got %h want %h", got, od[0], model(blks[got]));
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last != 5) begin failures++; $display("FAIL b2b_spacing%0d : got %0d want 5", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 8) id[0] = blks[sent];
                else          iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0;
        checks++;
        if (got != 8) begin failures++; $display("FAIL b2b_count : got %0d want 8", got); end
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] blk;
        logic [127:0] obs;
        int           lat;
        int           stray;
        logic         vld;
        bit           ok;
        ordy[0] = 1'b1;
        send(0, rnd128(), ok);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL midrst_valid : got %b want 0", ov[0]); end
        if (ir[0] !== 1'b0) begin failures++; $display("FAIL midrst_in_ready : got %b want 0", ir[0]); end
        if (od[0] !== '0)   begin failures++; $display("FAIL midrst_data : got %h want 0", od[0]); end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin failures++; $display("FAIL midrst_release_ready : got %b want 1", ir[0]); end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL midrst_stale_output : got %0d valid cycles want 0", stray); end
        tick();
        blk = rnd128();
        xfer(0, blk, obs, lat, vld);
        checks++;
        if (obs !== model(blk)) begin failures++; $display("FAIL midrst_next_data : got %h want %h", obs, model(blk)); end
    endtask

`ifdef INV_SUB_SHIFT_BLKCNT_EN
    task automatic test_blkcnt();
        logic [127:0] obs;
        int           lat;
        logic         vld;
        bit           ok;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (bc[0] !== 32'd0) begin failures++; $display("FAIL blkcnt_reset : got %h want 0", bc[0]); end
        ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) xfer(0, rnd128(), obs, lat, vld);
        ordy[0] = 1'b0;
        iv[1]   = 1'b0;
        send(0, rnd128(), ok);
        wait_out(0, lat);
        iv[0] = 1'b1;
        repeat (3) tick();
        iv[0] = 1'b0;
        checks += 2;
        if (ov[0] !== 1'b1)  begin failures++; $display("FAIL blkcnt_stall_valid : got %b want 1", ov[0]); end
        if (bc[0] !== 32'd3) begin failures++; $display("FAIL blkcnt_three : got %h want 3", bc[0]); end
        @(negedge clk);
        force g_dut[0].u_dut.blk_count_q = 32'hFFFF_FFFF;
        #1 release g_dut[0].u_dut.blk_count_q;
        ordy[0] = 1'b1;
        tick();
        checks++;
        if (bc[0] !== 32'd0) begin failures++; $display("FAIL blkcnt_wrap : got %h want 0", bc[0]); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog : simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        test_reset();
        test_fips();
        test_patterns();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef INV_SUB_SHIFT_BLKCNT_EN
        test_blkcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
